cla_pipe_adder: RTL and testbench
=================================

Name: cla_pipe_adder

Overview:
Parametrised, pipelined carry-lookahead adder/subtractor. It succeeds the fixed 4-bit combinational CLA. The operand word is split into BLOCK-bit CLA blocks, one block per pipeline stage, with the block carry registered between stages. A valid/ready handshake on both sides allows back-pressure, and the block sits directly in datapaths needing WIDTH-bit add/sub at high clock rates.

Parameters:
WIDTH, 16, operand/result width in bits; must be an integer multiple of BLOCK.
BLOCK, 4, bits per CLA block; each block uses internal 4-bit-style generate/propagate lookahead.
NSTAGE (derived, not overridable), WIDTH/BLOCK, number of pipeline stages and the latency in cycles.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  reset, asynchronous, active-high.
in_valid  input  1  operands presented this cycle.
in_ready  output  1  block accepts operands this cycle.
a  input  WIDTH  operand A (unsigned or two's complement).
b  input  WIDTH  operand B.
cin  input  1  carry in; used only when sub=0.
sub  input  1  0: a+b+cin; 1: a-b (a+~b+1, cin ignored).
out_valid  output  1  result valid.
out_ready  input  1  downstream accepts result.
sum  output  WIDTH  result.
cout  output  1  carry out of MSB (for sub: 1 = no borrow).
ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (async, any time): all stage valid bits clear. out_valid=0, sum=0, cout=0, ovf=0. in_ready=1 once rst is low. In-flight operations are discarded and never emerge.
- Advance enable: adv = !out_valid | out_ready. in_ready = adv, combinational from out_valid/out_ready only, with no dependence on in_valid.
- Transfer: input accepted when in_valid & in_ready. Output consumed when out_valid & out_ready.
- Pipeline: global stall. When adv=1, every stage shifts one position and stage 0 loads the input (valid bit = in_valid). When adv=0, all stages hold.
- Bubbles are not collapsed. An empty stage still costs its cycle.
- Stage k (k=0..NSTAGE-1) computes bits [k*BLOCK +: BLOCK] from the skewed operands plus the registered carry from stage k-1. Stage 0 carry-in is cin when sub=0 and 1 when sub=1.
- b is inverted at stage 0 when sub=1. The sub bit travels with the operands.
- Already-computed lower sum bits and not-yet-used upper operand bits are carried forward in the stage registers.
- Latency: an operation accepted at rising edge t appears with out_valid=1 after edge t+NSTAGE-1, i.e. NSTAGE cycles, provided there is no stall.
- Throughput is one operation per cycle with out_ready held high.
- Output registers (sum, cout, ovf, out_valid) are the final stage registers, with no combinational path from a/b to the outputs.
- Held output: while out_valid=1 and out_ready=0, sum/cout/ovf/out_valid must remain stable.
- Simultaneous events: the output is consumed and a new input accepted in the same cycle. Full pipeline with out_ready=1 gives continuous flow.
- Arithmetic: results wrap modulo 2^WIDTH. The ovf formula is identical for add and sub.

Test Plan:
Use WIDTH=16, BLOCK=4 (latency 4) for all scenarios.
- Basic add: a=16'h0001, b=16'h0002, cin=0, sub=0, single beat -> exactly 4 cycles later sum=16'h0003, cout=0, ovf=0, out_valid high for one cycle with out_ready=1.
- Full carry ripple across all stages: a=16'hFFFF, b=16'h0001, cin=0 -> sum=16'h0000, cout=1, ovf=0. Also a=16'hFFFF, b=16'h0000, cin=1 -> sum=16'h0000, cout=1.
- Signed overflow add: a=16'h7FFF, b=16'h0001 -> sum=16'h8000, cout=0, ovf=1.
- Subtract: a=16'h0005, b=16'h0007, sub=1, cin=1 (cin ignored) -> sum=16'hFFFE, cout=0, ovf=0. Also a=16'h8000, b=16'h0001, sub=1 -> sum=16'h7FFF, cout=1, ovf=1.
- Back-pressure: stream 8 random operations back-to-back, drop out_ready for 3 cycles mid-stream -> in_ready low exactly during the stall, outputs held stable, all 8 results correct, in order, no duplicates or drops, compared against a behavioural reference model.
- Reset mid-operation: 3 operations in flight, pulse rst asynchronously between edges -> out_valid=0 and sum=0 immediately. No result appears in the 6 cycles after release. A new operation issued afterwards completes with latency 4.

Source files
------------

// File: rtl/cla_pipe_adder_if.sv
`default_nettype none
// ============================================================================
//  Module   : cla_pipe_adder_if
//  Brief    : Operand/result valid-ready bundle for the pipelined CLA adder.
//  Revision : 1.0
// ============================================================================
interface cla_pipe_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface
`default_nettype wire

// File: rtl/cla_pipe_adder.sv
`default_nettype none
// ============================================================================
//  Module   : cla_pipe_adder
//  Brief    : Pipelined carry-lookahead add/sub, one BLOCK-bit CLA per stage.
//  Revision : 1.0
// ============================================================================
module cla_pipe_adder #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input  wire                    clk,
    input  wire                    rst,
    cla_pipe_adder_if.slave        bus
);

    localparam int NSTAGE = WIDTH / BLOCK;

    logic w_adv;

    // Returns {carry_out, sum}; each carry is a flat sum of generate/propagate
    // products rather than a ripple chain.
    function automatic logic [BLOCK:0] cla_blk(
        input logic [BLOCK-1:0] x,
        input logic [BLOCK-1:0] y,
        input logic             ci
    );
        logic [BLOCK-1:0] g;
        logic [BLOCK-1:0] p;
        logic [BLOCK-1:0] s;
        logic [BLOCK:0]   c;
        logic             prod;
        g    = x & y;
        p    = x ^ y;
        c    = '0;
        c[0] = ci;
        prod = 1'b0;
        for (int i = 0; i < BLOCK; i++) begin
            c[i+1] = g[i];
            prod   = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                c[i+1] = c[i+1] | (prod & g[j]);
                prod   = prod & p[j];
            end
            c[i+1] = c[i+1] | (prod & ci);
        end
        s = p ^ c[BLOCK-1:0];
        return {c[BLOCK], s};
    endfunction

    for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
        localparam int c_IW = WIDTH - k * BLOCK;

        logic [c_IW-1:0]          w_a;
        logic [c_IW-1:0]          w_b;
        logic                     w_ci;
        logic                     w_vi;
        logic [BLOCK:0]           w_r;
        logic [(k+1)*BLOCK-1:0]   w_s;
        logic [(k+1)*BLOCK-1:0]   r_s;
        logic                     r_c;
        logic                     r_v;

        if (k == 0) begin : g_entry
            // Inverting b here makes the sub flag redundant in later stages.
            assign w_a  = bus.a;
            assign w_b  = bus.sub ? ~bus.b : bus.b;
            assign w_ci = bus.sub | bus.cin;
            assign w_vi = bus.in_valid;
            assign w_s  = w_r[BLOCK-1:0];
        end else begin : g_chain
            assign w_a  = g_stage[k-1].g_fwd.r_a;
            assign w_b  = g_stage[k-1].g_fwd.r_b;
            assign w_ci = g_stage[k-1].r_c;
            assign w_vi = g_stage[k-1].r_v;
            assign w_s  = {w_r[BLOCK-1:0], g_stage[k-1].r_s};
        end

        assign w_r = cla_blk(w_a[BLOCK-1:0], w_b[BLOCK-1:0], w_ci);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_v <= 1'b0;
                r_c <= 1'b0;
                r_s <= '0;
            end else if (w_adv) begin
                r_v <= w_vi;
                r_c <= w_r[BLOCK];
                r_s <= w_s;
            end
        end

        if (k < NSTAGE - 1) begin : g_fwd
            logic [c_IW-BLOCK-1:0] r_a;
            logic [c_IW-BLOCK-1:0] r_b;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_adv) begin
                    r_a <= w_a[c_IW-1:BLOCK];
                    r_b <= w_b[c_IW-1:BLOCK];
                end
            end
        end else begin : g_last
            logic r_ovf;

            // Carry into the MSB is recovered as sum ^ a ^ b at that bit.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_ovf <= 1'b0;
                end else if (w_adv) begin
                    r_ovf <= w_r[BLOCK] ^
                             (w_r[BLOCK-1] ^ w_a[BLOCK-1] ^ w_b[BLOCK-1]);
                end
            end
        end
    end

    assign w_adv        = ~g_stage[NSTAGE-1].r_v | bus.out_ready;
    assign bus.in_ready = w_adv;
    assign bus.out_valid = g_stage[NSTAGE-1].r_v;
    assign bus.sum      = g_stage[NSTAGE-1].r_s;
    assign bus.cout     = g_stage[NSTAGE-1].r_c;
    assign bus.ovf      = g_stage[NSTAGE-1].g_last.r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_cla_pipe_adder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cla_pipe_adder
//  Brief    : Directed self-checking bench for cla_pipe_adder (16-bit, 4 stages).
//  Revision : 1.0
// ============================================================================
module tb_cla_pipe_adder;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    cla_pipe_adder_if #(.WIDTH(16)) bus ();

    cla_pipe_adder #(.WIDTH(16), .BLOCK(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: {ovf, cout, sum} from plain integer arithmetic.
    function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic cin, input logic sub);
        logic [15:0] bb;
        logic [16:0] full;
        logic        ov;
        bb   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + {16'd0, (sub ? 1'b1 : cin)};
        ov   = (a[15] == bb[15]) && (full[15] != a[15]);
        return {ov, full};
    endfunction

    // One isolated operation: checks latency of exactly 4 and a one-cycle result.
    task automatic single(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic sub,
                          input logic [15:0] esum, input logic ecout, input logic eovf);
        bus.out_ready = 1'b1;
        bus.a = a; bus.b = b; bus.cin = cin; bus.sub = sub;
        bus.in_valid = 1'b1;
        #1;
        chk({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
        step();
        bus.in_valid = 1'b0;
        chk({tag, "_lat1"}, {31'd0, bus.out_valid}, 32'd0);
        step();
        chk({tag, "_lat2"}, {31'd0, bus.out_valid}, 32'd0);
        step();
        chk({tag, "_lat3"}, {31'd0, bus.out_valid}, 32'd0);
        step();
        chk({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
        chk({tag, "_sum"},   {16'd0, bus.sum},       {16'd0, esum});
        chk({tag, "_cout"},  {31'd0, bus.cout},      {31'd0, ecout});
        chk({tag, "_ovf"},   {31'd0, bus.ovf},       {31'd0, eovf});
        step();
        chk({tag, "_drop"},  {31'd0, bus.out_valid}, 32'd0);
    endtask

    logic [15:0] va [8];
    logic [15:0] vb [8];
    logic        vc [8];
    logic        vs [8];
    logic [17:0] ve [8];

    initial begin
        int          idx;
        int          oidx;
        int          cyc;
        logic        stall;
        logic        acc;
        logic [15:0] held;

        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0;

        step();
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_sum",       {16'd0, bus.sum},       32'd0);
        chk("rst_cout",      {31'd0, bus.cout},      32'd0);
        chk("rst_ovf",       {31'd0, bus.ovf},       32'd0);
        #3 rst = 1'b0;
        step();
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

        single("add_basic",  16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0);
        single("add_ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        single("add_cin",    16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        single("add_ovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        single("add_cin2",   16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);
        single("sub_neg",    16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        single("sub_ovf",    16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

        // Back-pressure: 8 back-to-back operations, out_ready low in slots 5..7.
        va = '{16'hA5A5, 16'h1F3C, 16'hFFFF, 16'h7000, 16'h0F0F, 16'h8001, 16'h3333, 16'hC0DE};
        vb = '{16'h5A5A, 16'h00C4, 16'hFFFF, 16'h1000, 16'hF0F0, 16'h0002, 16'h4444, 16'hBEEF};
        vc = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vs = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 8; i++) ve[i] = model(va[i], vb[i], vc[i], vs[i]);

        idx  = 0;
        oidx = 0;
        held = '0;
        for (cyc = 0; cyc < 40 && oidx < 8; cyc++) begin
            stall = (cyc >= 5) && (cyc <= 7);
            bus.out_ready = ~stall;
            bus.in_valid  = (idx < 8);
            if (idx < 8) begin
                bus.a = va[idx]; bus.b = vb[idx]; bus.cin = vc[idx]; bus.sub = vs[idx];
            end
            #1;
            chk("bp_in_ready", {31'd0, bus.in_ready}, {31'd0, ~stall});
            if (stall) begin
                chk("bp_hold_valid", {31'd0, bus.out_valid}, 32'd1);
                if (cyc > 5) chk("bp_hold_sum", {16'd0, bus.sum}, {16'd0, held});
                held = bus.sum;
            end else if (bus.out_valid) begin
                chk("bp_sum",  {16'd0, bus.sum},  {16'd0, ve[oidx][15:0]});
                chk("bp_cout", {31'd0, bus.cout}, {31'd0, ve[oidx][16]});
                chk("bp_ovf",  {31'd0, bus.ovf},  {31'd0, ve[oidx][17]});
                oidx++;
            end
            acc = bus.in_valid & bus.in_ready;
            @(posedge clk);
            #1;
            if (acc) idx++;
        end
        chk("bp_count", oidx, 32'd8);
        chk("bp_accepted", idx, 32'd8);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        step();

        // Reset with the pipeline full and a valid result on the output.
        for (int i = 0; i < 4; i++) begin
            bus.a = 16'h1111 * (i + 1); bus.b = 16'h2222; bus.cin = 1'b0; bus.sub = 1'b0;
            bus.in_valid = 1'b1;
            step();
        end
        bus.in_valid = 1'b0;
        chk("rstmid_pre_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("rstmid_pre_sum",   {16'd0, bus.sum},       32'h3333);
        #3 rst = 1'b1;
        #1;
        chk("rstmid_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rstmid_sum",   {16'd0, bus.sum},       32'd0);
        chk("rstmid_cout",  {31'd0, bus.cout},      32'd0);
        @(posedge clk);
        #4 rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("rstmid_quiet", {31'd0, bus.out_valid}, 32'd0);
        end
        single("post_rst", 16'h00FF, 16'h0F01, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
